// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage, one-cycle latency, stall/flush aware
// Optional build macro: DECODE_ILLEGAL_CHECK_EN (adds illegal-instruction detection on d_o_illegal)
module instruction_decode #(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DWIDTH     = 32,
  parameter int REG_AWIDTH = 5
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic [IWIDTH-1:0]     d_i_instr,
  input  logic [PC_WIDTH-1:0]   d_i_pc,
  input  logic                  d_i_ce,
  input  logic                  d_i_stall,
  input  logic                  d_i_flush,
  output logic                  d_o_stall,
  output logic                  d_o_ce,
  output logic [PC_WIDTH-1:0]   d_o_pc,
  output logic [IWIDTH-1:0]     d_o_instr,
  output logic [REG_AWIDTH-1:0] d_o_rs1_addr,
  output logic [REG_AWIDTH-1:0] d_o_rs2_addr,
  output logic [REG_AWIDTH-1:0] d_o_rd_addr,
  output logic [DWIDTH-1:0]     d_o_imm,
  output logic [2:0]            d_o_funct3,
  output logic                  d_o_funct7_b5,
  output logic [10:0]           d_o_opcode,
  output logic                  d_o_illegal
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [31:0]       instr;
  logic [10:0]       opc_c;
  logic [DWIDTH-1:0] imm_c;
  logic [4:0]        rs1_c;
  logic [4:0]        rs2_c;
  logic [4:0]        rd_c;

  assign instr     = d_i_instr[31:0];
  assign d_o_stall = d_i_stall;

  // Combinational field decode of the incoming instruction
  always_comb begin
    opc_c = '0;
    imm_c = '0;
    rs1_c = instr[19:15];
    rs2_c = '0;
    rd_c  = instr[11:7];
    case (instr[6:0])
      OP_RTYPE: begin
        opc_c[0] = 1'b1;
        rs2_c    = instr[24:20];
      end
      OP_ITYPE: begin
        opc_c[1]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[11:0]  = instr[31:20];
      end
      OP_LOAD: begin
        opc_c[2]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[11:0]  = instr[31:20];
      end
      OP_STORE: begin
        opc_c[3]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[11:0]  = {instr[31:25], instr[11:7]};
        rs2_c        = instr[24:20];
        rd_c         = '0;
      end
      OP_BRANCH: begin
        opc_c[4]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[12:0]  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        rs2_c        = instr[24:20];
        rd_c         = '0;
      end
      OP_JAL: begin
        opc_c[5]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[20:0]  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        rs1_c        = '0;
      end
      OP_JALR: begin
        opc_c[6]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[11:0]  = instr[31:20];
      end
      OP_LUI: begin
        opc_c[7]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[31:0]  = {instr[31:12], 12'b0};
        rs1_c        = '0;
      end
      OP_AUIPC: begin
        opc_c[8]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[31:0]  = {instr[31:12], 12'b0};
        rs1_c        = '0;
      end
      OP_SYSTEM: begin
        opc_c[9]     = 1'b1;
        imm_c        = {DWIDTH{instr[31]}};
        imm_c[11:0]  = instr[31:20];
      end
      OP_FENCE: begin
        opc_c[10]    = 1'b1;
        rs1_c        = '0;
        rd_c         = '0;
      end
      default: ;
    endcase
  end

  // Pipeline register: reset > flush > stall > capture > bubble
  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      d_o_ce        <= 1'b0;
      d_o_pc        <= '0;
      d_o_instr     <= '0;
      d_o_rs1_addr  <= '0;
      d_o_rs2_addr  <= '0;
      d_o_rd_addr   <= '0;
      d_o_imm       <= '0;
      d_o_funct3    <= '0;
      d_o_funct7_b5 <= 1'b0;
      d_o_opcode    <= '0;
    end else if (d_i_flush) begin
      d_o_ce <= 1'b0;
    end else if (d_i_stall) begin
      d_o_ce <= d_o_ce;
    end else if (d_i_ce) begin
      d_o_ce        <= 1'b1;
      d_o_pc        <= d_i_pc;
      d_o_instr     <= d_i_instr;
      d_o_rs1_addr  <= REG_AWIDTH'(rs1_c);
      d_o_rs2_addr  <= REG_AWIDTH'(rs2_c);
      d_o_rd_addr   <= REG_AWIDTH'(rd_c);
      d_o_imm       <= imm_c;
      d_o_funct3    <= instr[14:12];
      d_o_funct7_b5 <= instr[30];
      d_o_opcode    <= opc_c;
    end else begin
      d_o_ce <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic illegal_c;

  // Flag unmapped opcodes and reserved funct7/funct3 combinations
  always_comb begin
    illegal_c = 1'b0;
    if (opc_c == '0 || instr[1:0] != 2'b11)
      illegal_c = 1'b1;
    if (opc_c[0]) begin
      if (instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000)
        illegal_c = 1'b1;
      if (instr[31:25] == 7'b0100000 && instr[14:12] != 3'b000 && instr[14:12] != 3'b101)
        illegal_c = 1'b1;
    end
    if (opc_c[1]) begin
      if (instr[14:12] == 3'b001 && instr[31:25] != 7'b0000000)
        illegal_c = 1'b1;
      if (instr[14:12] == 3'b101 && instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000)
        illegal_c = 1'b1;
    end
  end

  // Illegal flag follows the data path but is cleared by flush
  always_ff @(posedge d_clk) begin
    if (!d_rst)
      d_o_illegal <= 1'b0;
    else if (d_i_flush)
      d_o_illegal <= 1'b0;
    else if (!d_i_stall && d_i_ce)
      d_o_illegal <= illegal_c;
  end
`else
  assign d_o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - table-driven scoreboard bench for instruction_decode
module tb_instruction_decode;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [10:0] opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } vec_t;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic [31:0] d_i_instr;
  logic [31:0] d_i_pc;
  logic        d_i_ce;
  logic        d_i_stall;
  logic        d_i_flush;
  logic        d_o_stall;
  logic        d_o_ce;
  logic [31:0] d_o_pc;
  logic [31:0] d_o_instr;
  logic [4:0]  d_o_rs1_addr;
  logic [4:0]  d_o_rs2_addr;
  logic [4:0]  d_o_rd_addr;
  logic [31:0] d_o_imm;
  logic [2:0]  d_o_funct3;
  logic        d_o_funct7_b5;
  logic [10:0] d_o_opcode;
  logic        d_o_illegal;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vt[15];
  vec_t sb[$];
  vec_t zero_v;
  vec_t tmp;

  instruction_decode dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_instr(d_i_instr), .d_i_pc(d_i_pc),
    .d_i_ce(d_i_ce), .d_i_stall(d_i_stall), .d_i_flush(d_i_flush),
    .d_o_stall(d_o_stall), .d_o_ce(d_o_ce), .d_o_pc(d_o_pc), .d_o_instr(d_o_instr),
    .d_o_rs1_addr(d_o_rs1_addr), .d_o_rs2_addr(d_o_rs2_addr), .d_o_rd_addr(d_o_rd_addr),
    .d_o_imm(d_o_imm), .d_o_funct3(d_o_funct3), .d_o_funct7_b5(d_o_funct7_b5),
    .d_o_opcode(d_o_opcode), .d_o_illegal(d_o_illegal)
  );

  always #5 d_clk = ~d_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_rec(input vec_t e, input logic exp_ce, input string tag);
    chk({tag, ".ce"},      32'(d_o_ce), 32'(exp_ce));
    chk({tag, ".pc"},      d_o_pc, e.pc);
    chk({tag, ".instr"},   d_o_instr, e.instr);
    chk({tag, ".opcode"},  32'(d_o_opcode), 32'(e.opc));
    chk({tag, ".rs1"},     32'(d_o_rs1_addr), 32'(e.rs1));
    chk({tag, ".rs2"},     32'(d_o_rs2_addr), 32'(e.rs2));
    chk({tag, ".rd"},      32'(d_o_rd_addr), 32'(e.rd));
    chk({tag, ".imm"},     d_o_imm, e.imm);
    chk({tag, ".funct3"},  32'(d_o_funct3), 32'(e.f3));
    chk({tag, ".f7b5"},    32'(d_o_funct7_b5), 32'(e.f7));
    chk({tag, ".illegal"}, 32'(d_o_illegal), 32'(e.ill & ILL_EN));
  endtask

  task automatic drive(input logic ce, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    d_i_ce    = ce;
    d_i_instr = ins;
    d_i_pc    = pc;
    d_i_stall = st;
    d_i_flush = fl;
  endtask

  task automatic step();
    @(posedge d_clk);
    #1;
  endtask

  task automatic check_sb(input string tag);
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got ce %0d expected a queued result", tag, d_o_ce);
    end else begin
      n_pass++;
      compare_rec(sb.pop_front(), 1'b1, tag);
    end
  endtask

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] pc, logic [10:0] opc,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] imm, logic [2:0] f3, logic f7, logic ill);
    vec_t v;
    v.instr = ins; v.pc = pc; v.opc = opc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.f3 = f3; v.f7 = f7; v.ill = ill;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(32'hFFB10093, 32'h100, 11'h002, 2,  0, 1,  32'hFFFFFFFB, 3'd0, 1'b1, 1'b0);
    vt[1]  = mk(32'h00532423, 32'h104, 11'h008, 6,  5, 0,  32'h00000008, 3'd2, 1'b0, 1'b0);
    vt[2]  = mk(32'hFE000EE3, 32'h108, 11'h010, 0,  0, 0,  32'hFFFFFFFC, 3'd0, 1'b1, 1'b0);
    vt[3]  = mk(32'h123451B7, 32'h10C, 11'h080, 0,  0, 3,  32'h12345000, 3'd5, 1'b0, 1'b0);
    vt[4]  = mk(32'h002081B3, 32'h110, 11'h001, 1,  2, 3,  32'h00000000, 3'd0, 1'b0, 1'b0);
    vt[5]  = mk(32'h008000EF, 32'h114, 11'h020, 0,  0, 1,  32'h00000008, 3'd0, 1'b0, 1'b0);
    vt[6]  = mk(32'hFFFFF297, 32'h118, 11'h100, 0,  0, 5,  32'hFFFFF000, 3'd7, 1'b1, 1'b0);
    vt[7]  = mk(32'hFFF52383, 32'h11C, 11'h004, 10, 0, 7,  32'hFFFFFFFF, 3'd2, 1'b1, 1'b0);
    vt[8]  = mk(32'h00008067, 32'h120, 11'h040, 1,  0, 0,  32'h00000000, 3'd0, 1'b0, 1'b0);
    vt[9]  = mk(32'h0FF0000F, 32'h124, 11'h400, 0,  0, 0,  32'h00000000, 3'd0, 1'b0, 1'b0);
    vt[10] = mk(32'h00000073, 32'h128, 11'h200, 0,  0, 0,  32'h00000000, 3'd0, 1'b0, 1'b0);
    vt[11] = mk(32'h40F0D093, 32'h12C, 11'h002, 1,  0, 1,  32'h0000040F, 3'd5, 1'b1, 1'b0);
    vt[12] = mk(32'h02009093, 32'h130, 11'h002, 1,  0, 1,  32'h00000020, 3'd1, 1'b0, 1'b1);
    vt[13] = mk(32'hFFFFFFFF, 32'h134, 11'h000, 31, 0, 31, 32'h00000000, 3'd7, 1'b1, 1'b1);
    vt[14] = mk(32'h40001033, 32'h138, 11'h001, 0,  0, 0,  32'h00000000, 3'd1, 1'b1, 1'b1);
    zero_v = mk(32'h0, 32'h0, 11'h0, 0, 0, 0, 32'h0, 3'd0, 1'b0, 1'b0);

    // reset held two cycles with a valid instruction presented
    d_rst = 1'b0;
    drive(1'b1, vt[0].instr, vt[0].pc, 1'b0, 1'b0);
    step();
    step();
    compare_rec(zero_v, 1'b0, "reset");
    chk("reset.stall", 32'(d_o_stall), 32'd0);
    d_rst = 1'b1;

    // back-to-back table
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vt[i].instr, vt[i].pc, 1'b0, 1'b0);
      sb.push_back(vt[i]);
      step();
      check_sb($sformatf("vec%0d", i));
    end

    // stall holds while the fetched word changes underneath
    drive(1'b1, vt[0].instr, vt[0].pc, 1'b0, 1'b0);
    sb.push_back(vt[0]);
    step();
    check_sb("stall_cap");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, vt[1].instr, vt[1].pc, 1'b1, 1'b0);
      step();
      compare_rec(vt[0], 1'b1, $sformatf("stall%0d", k));
      chk($sformatf("stall%0d.o_stall", k), 32'(d_o_stall), 32'd1);
    end
    drive(1'b1, vt[1].instr, vt[1].pc, 1'b0, 1'b0);
    sb.push_back(vt[1]);
    step();
    check_sb("stall_rel");

    // flush beats stall; then a bubble keeps data
    drive(1'b1, vt[2].instr, vt[2].pc, 1'b1, 1'b1);
    step();
    compare_rec(vt[1], 1'b0, "flush");
    drive(1'b0, vt[3].instr, vt[3].pc, 1'b0, 1'b0);
    step();
    compare_rec(vt[1], 1'b0, "bubble");

    // illegal flag cleared by flush, data held
    drive(1'b1, vt[13].instr, vt[13].pc, 1'b0, 1'b0);
    sb.push_back(vt[13]);
    step();
    check_sb("ill_cap");
    drive(1'b1, vt[4].instr, vt[4].pc, 1'b0, 1'b1);
    step();
    tmp = vt[13];
    tmp.ill = 1'b0;
    compare_rec(tmp, 1'b0, "ill_flush");

    // reset mid-operation discards the held instruction
    drive(1'b1, vt[3].instr, vt[3].pc, 1'b0, 1'b0);
    sb.push_back(vt[3]);
    step();
    check_sb("pre_rst");
    d_rst = 1'b0;
    step();
    compare_rec(zero_v, 1'b0, "mid_rst");
    d_rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
